// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared types for the bimodal predictor and BTB
package branch_predictor_pkg;
    localparam int MAX_TAG_W = 32;
    typedef enum logic [1:0] {SNT, WNT, WT, ST} ctr_t;
    localparam ctr_t CTR_RST = WNT;
    typedef enum logic {INIT, RUN} state_t;
    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;
endpackage

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next value of a 2-bit saturating direction counter
import branch_predictor_pkg::*;
module bp_sat_counter (
    input  ctr_t cnt,
    input  logic taken,
    output ctr_t nxt
);
    always_comb nxt = taken ? (cnt == ST ? ST : ctr_t'(cnt + 2'd1))
                            : (cnt == SNT ? SNT : ctr_t'(cnt - 2'd1));
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor plus direct-mapped BTB with post-reset table sweep.
// Define BP_GSHARE_EN to xor a global history register into the counter index.
import branch_predictor_pkg::*;
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    output logic        o_ready,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target
);
    localparam int IDX_W = $clog2(ENTRIES);
    ctr_t              cnt [ENTRIES];
    btb_entry_t        btb [ENTRIES];
    state_t            state;
    logic [IDX_W-1:0]  ptr, idx, uidx, cidx, ucidx;
    logic [TAG_W-1:0]  tag, utag;
    ctr_t              nxt;
    logic              hit, unused;
    assign idx    = i_pc[IDX_W+1:2];
    assign uidx   = i_upd_pc[IDX_W+1:2];
    assign tag    = i_pc[IDX_W+2 +: TAG_W];
    assign utag   = i_upd_pc[IDX_W+2 +: TAG_W];
    assign unused = ^{i_pc, i_upd_pc};
`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;
    assign cidx  = idx ^ ghr;
    assign ucidx = uidx ^ ghr;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            ghr <= '0;
        else if (state == RUN && i_upd_valid)
            ghr <= {ghr[IDX_W-2:0], i_upd_taken};
    end
`else
    assign cidx  = idx;
    assign ucidx = uidx;
`endif
    bp_sat_counter u_ctr (.cnt(cnt[ucidx]), .taken(i_upd_taken), .nxt(nxt));
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= INIT;
            ptr   <= '0;
        end else if (state == INIT) begin
            ptr <= ptr + 1'b1;
            if (ptr == IDX_W'(ENTRIES - 1))
                state <= RUN;
        end
    end
    // Tables carry no reset so they can map onto RAM; the sweep initialises them.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == INIT) begin
                cnt[ptr] <= CTR_RST;
                btb[ptr] <= '0;
            end else if (i_upd_valid) begin
                cnt[ucidx] <= nxt;
                if (i_upd_taken)
                    btb[uidx] <= '{valid: 1'b1, tag: MAX_TAG_W'(utag), target: i_upd_target};
            end
        end
    end
    always_comb begin
        o_ready       = state == RUN && !i_rst;
        hit           = btb[idx].valid && btb[idx].tag == MAX_TAG_W'(tag);
        o_pred_taken  = o_ready && cnt[cidx][1] && hit;
        o_pred_target = o_pred_taken ? btb[idx].target : 32'd0;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of init sweep, training, hysteresis, tags and reset
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ready;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    int          total = 0;
    int          passed = 0;
    int          nready;

    branch_predictor dut (
        .i_clk(clk), .i_rst(rst), .i_pc(pc),
        .o_pred_taken(pred_taken), .o_pred_target(pred_target), .o_ready(ready),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
        .i_upd_taken(upd_taken), .i_upd_target(upd_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt);
        upd_valid = 1'b1;
        upd_pc = p;
        upd_taken = t;
        upd_target = tgt;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] p, input logic t, input logic [31:0] tgt);
        pc = p;
        #1;
        chk({tag, "_taken"}, 32'(pred_taken), 32'(t));
        chk({tag, "_target"}, pred_target, tgt);
    endtask

    initial begin
        pc = 32'h100;
        tick();
        chk("rst_ready", 32'(ready), 0);
        chk("rst_taken", 32'(pred_taken), 0);
        tick();
        rst = 1'b0;
        nready = 0;
        for (int i = 0; i < 64; i++) begin
            if (!ready) nready++;
            if (pred_taken) nready += 1000;
            tick();
        end
        chk("init_cycles", 32'(nready), 64);
        chk("ready_up", 32'(ready), 1);
        look("fresh", 32'h100, 1'b0, 0);

        upd(32'h100, 1'b1, 32'h80);
        look("train", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 32'h80);
        look("strong", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h0);
        look("hyst_nt1", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h0);
        look("hyst_nt2", 32'h100, 1'b0, 0);

        upd(32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 32'h80);
        look("alias_tag", 32'h200, 1'b0, 0);
        look("retrained", 32'h100, 1'b1, 32'h80);

        pc = 32'h140;
        upd_valid = 1'b1;
        upd_pc = 32'h140;
        upd_taken = 1'b1;
        upd_target = 32'h444;
        #1;
        chk("same_cycle", 32'(pred_taken), 0);
        tick();
        upd_valid = 1'b0;
        look("after_upd", 32'h140, 1'b1, 32'h444);

        upd(32'h140, 1'b0, 0);
        upd(32'h140, 1'b0, 0);
        upd(32'h140, 1'b0, 0);
        upd(32'h140, 1'b1, 32'h444);
        look("floor", 32'h140, 1'b0, 0);
        upd(32'h140, 1'b1, 32'h444);
        look("floor_up", 32'h140, 1'b1, 32'h444);

        upd(32'hFC, 1'b1, 32'h1234);
        look("last_idx", 32'hFC, 1'b1, 32'h1234);

        pc = 32'h100;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 0);
        chk("midrst_taken", 32'(pred_taken), 0);
        chk("midrst_target", pred_target, 0);
        tick();
        rst = 1'b0;
        upd_valid = 1'b1;
        upd_pc = 32'h100;
        upd_taken = 1'b1;
        upd_target = 32'h55;
        nready = 0;
        for (int i = 0; i < 64; i++) begin
            if (!ready) nready++;
            tick();
        end
        upd_valid = 1'b0;
        chk("reinit_cycles", 32'(nready), 64);
        chk("reinit_ready", 32'(ready), 1);
        look("forgot", 32'h100, 1'b0, 0);
        look("forgot_last", 32'hFC, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal direction predictor with a direct-mapped branch target buffer (BTB), sitting beside the fetch stage. It gives fetch a same-cycle taken/target prediction for the current PC. It is trained by the resolved outcome of conditional branches from the execute-stage branch unit (its `o_taken`). After every reset, a sequential sweep clears the tables so they can map to RAM-style storage.

## Interface
Parameters:
- `ENTRIES`, 64, table depth; power of two, ≥4; `IDX_W = $clog2(ENTRIES)`
- `TAG_W`, 8, BTB tag width

Ports:
- `i_clk`  in  1  clock; single clock domain
- `i_rst`  in  1  reset; synchronous, active-high
- `i_pc`  in  32  fetch PC to predict
- `o_pred_taken`  out  1  predict taken
- `o_pred_target`  out  32  predicted target; 0 when `o_pred_taken`=0
- `o_ready`  out  1  tables initialised, predictor live
- `i_upd_valid`  in  1  a conditional branch resolved this cycle
- `i_upd_pc`  in  32  PC of resolved branch
- `i_upd_taken`  in  1  resolved direction
- `i_upd_target`  in  32  resolved target address

## Operation
- Index: `idx = pc[IDX_W+1:2]`. Tag: `tag = pc[IDX_W+2 +: TAG_W]`.
- Per-entry state:
  - 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  - BTB valid bit, tag and target
- FSM has two states, INIT and RUN.
- While `i_rst`=1:
  - State goes to INIT with sweep pointer 0.
  - No table writes.
  - All outputs are 0.
- INIT, each cycle with `i_rst`=0:
  - Write entry[ptr] with counter=01 and valid=0, then increment ptr.
  - After writing entry ENTRIES-1, go to RUN.
  - `i_upd_valid` is ignored.
  - `o_pred_taken`=0, `o_pred_target`=0, `o_ready`=0.
- RUN:
  - `o_ready`=1.
  - `o_pred_taken = counter[idx][1] & valid[idx] & (tag[idx]==tag(i_pc))`.
  - `o_pred_target = target[idx]` when `o_pred_taken`=1, else 0.
- Update in RUN with `i_upd_valid`=1, at index/tag of `i_upd_pc`:
  - Counter saturates: +1 when taken (capped at 11), −1 when not taken (floored at 00).
  - Taken: write valid=1, tag, and target=`i_upd_target`.
  - Not taken: BTB entry unchanged.
  - A tag mismatch still updates the shared counter (aliasing is accepted).
- Reset asserted mid-sweep or during RUN restarts INIT from ptr 0, and all learned state is lost.

## Timing
- Prediction is combinational from stored state: zero latency relative to `i_pc`.
- An update written at edge N is visible to lookups after edge N.
- A lookup and update to the same entry in the same cycle returns the pre-update value (no bypass).
- Init latency:
  - Let the edge that samples `i_rst`=1 be E0.
  - The first edge with `i_rst`=0 is E1.
  - `o_ready` becomes 1 after edge E_ENTRIES, i.e. ENTRIES cycles of `i_rst`=0.
- Reset values: `o_pred_taken`=0, `o_pred_target`=0, `o_ready`=0.

## Configuration
- Macro: `BP_GSHARE_EN`.
- Defined:
  - Global history register `ghr` [IDX_W-1:0], reset to 0 on `i_rst`.
  - Counter index becomes `pc[IDX_W+1:2] ^ ghr`, for both lookup and update.
  - The update uses `ghr` before the shift.
  - On a RUN update: `ghr <= {ghr[IDX_W-2:0], i_upd_taken}`.
  - The BTB keeps the plain `idx`.
- Undefined: plain bimodal, with no history register.

## Structure
- Shared package holds:
  - counter encoding typedef (SNT/WNT/WT/ST) and reset value WNT
  - FSM state enum (INIT, RUN)
  - BTB entry struct (valid, tag, target)
- One sub-module: `bp_sat_counter`, the 2-bit saturating next-value function with inputs counter and taken.

## Test plan
ENTRIES=64, TAG_W=8, `BP_GSHARE_EN` undefined unless stated.
- Reset: `i_rst`=1 for 2 cycles, then 0 → `o_ready`=0 for exactly 64 cycles, then 1; `o_pred_taken`=0 throughout.
- Train: update pc 0x100, taken, target 0x80 → next cycle, `i_pc`=0x100 gives taken with target 0x80.
- Hysteresis on pc 0x100: T,T,T gives counter 11; then NT → still taken (10); NT again → not taken (01), target output 0.
- Tag mismatch: after training 0x100, `i_pc`=0x200 (same idx 0, tag 2≠1) → not taken.
- Same-cycle: update 0x140 taken with `i_pc`=0x140 in the same cycle → not taken that cycle, taken the next.
- Reset mid-run: after training, `i_rst`=1 for one cycle; updates driven during INIT are ignored; after 64 cycles, 0x100 predicts not taken. With `BP_GSHARE_EN`: the same history-dependent branch pattern T,NT alternating trains separate counters.
